dma_ram_arbiter: RTL
====================

DMA_RAM_ARBITER -- requirements
Module: dma_ram_arbiter

Interface
REQ-001 SHALL have parameter bitwidth, default 32, meaning the data word width.
REQ-002 SHALL have parameter nrOfEntries, default 512, meaning the RAM depth; address width is $clog2(nrOfEntries).
REQ-003 SHALL have parameter maxBurst, default 16, meaning the maximum consecutive locked grants to one requester.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ports req0/req1, input, 1 each, meaning the access request from requester 0 (DMA bus engine) and requester 1 (CPU custom instruction).
REQ-007 SHALL have ports lock0/lock1, input, 1 each, meaning the owner asks to keep the grant next cycle.
REQ-008 SHALL have ports we0/we1, input, 1 each, meaning the access is a write.
REQ-009 SHALL have ports addr0/addr1, input, addr width, meaning the access address.
REQ-010 SHALL have ports wdata0/wdata1, input, bitwidth, meaning the write data.
REQ-011 SHALL have ports grant0/grant1, output, 1 each, meaning the access is taken this cycle.
REQ-012 SHALL have ports rvalid0/rvalid1, output, 1 each, meaning read data is valid.
REQ-013 SHALL have ports rdata0/rdata1, output, bitwidth each, meaning the read data.
REQ-014 SHALL have ports memWriteEnable, memAddress, memDataIn, output, 1/addr width/bitwidth, meaning the shared RAM port drive.
REQ-015 SHALL have port memDataOut, input, bitwidth, meaning the RAM read data.

Function
REQ-016 SHALL produce grants combinationally in the request cycle; at most one grant is high per cycle.
REQ-017 SHALL give a single requester the grant whenever it requests alone and no lock is held by the other.
REQ-018 SHALL, on simultaneous req0 and req1 without an active lock, grant the requester that was not granted last (round robin via register lastGrant).
REQ-019 SHALL drive memWriteEnable = granted we, memAddress/memDataIn = granted addr/wdata; with no grant, memWriteEnable=0 and address/data=0.
REQ-020 SHALL pulse rvalidN for exactly one cycle, in the cycle after a granted read by requester N; rdataN = memDataOut during that cycle; granted writes produce no rvalid.
REQ-021 SHALL hold rdataN at zero when rvalidN is low.
REQ-022 SHALL keep an active lock while the owner asserts reqN and lockN in each granted cycle, with a burst counter incremented on each locked grant.
REQ-023 SHALL force lock release when the burst counter reaches maxBurst: the next cycle grants the other requester if it requests; otherwise the owner may continue and the counter restarts at 1.
REQ-024 SHALL drop the lock immediately when the owner deasserts reqN or lockN; the counter clears.
REQ-025 SHALL ignore lockN from a requester that is not granted.

Reset
REQ-026 SHALL, with reset high at a rising edge, set lastGrant=1 (requester 0 wins the first tie), lock inactive, burst counter 0, rvalid0/rvalid1=0.
REQ-027 SHALL produce no grant while reset is high; a burst interrupted by reset is abandoned and its pending rvalid is not issued.

Configuration
REQ-028 SHALL, with macro DMA_RAM_ARBITER_STATS_EN defined, add outputs grantCount0, grantCount1, conflictCount (16 bits each, saturating, cleared by reset); conflictCount increments on cycles with both req high.
REQ-029 SHALL, without DMA_RAM_ARBITER_STATS_EN, omit these ports and counters entirely.

Structure
REQ-030 SHALL take requester-index constants (REQ_DMA=0, REQ_CPU=1) and the 16-bit counter width from shared package dma_pkg.
REQ-031 SHALL contain no RAM; dualPortSSRAM port B is instantiated by the parent and connected to the mem* ports; a sub-module dma_ram_burst_counter (counter plus maxBurst compare) is natural.

Verification
REQ-032 SHALL cover: reset, then req0=req1=1 read addr 5/9 for 2 cycles -> grant0 then grant1; rvalid0 next cycle with word 5, then rvalid1 with word 9.
REQ-033 SHALL cover: req1 write addr 3 data 0xA5A5A5A5, then req0 read addr 3 -> rvalid0 with 0xA5A5A5A5; no rvalid1.
REQ-034 SHALL cover: req0+lock0 held 20 cycles, req1 high throughout -> 16 grant0, then grant1 in cycle 17.
REQ-035 SHALL cover: reset asserted during a locked read burst -> grants 0 immediately, no rvalid next cycle, post-reset tie goes to requester 0.
REQ-036 SHALL cover: with DMA_RAM_ARBITER_STATS_EN, 10 conflict cycles -> conflictCount=10, grantCount0=5, grantCount1=5.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA RAM arbiter: requester indices, lock-owner encoding
// and the statistics counter width with its saturating increment helper.
package dma_pkg;

    localparam int REQ_DMA = 0;
    localparam int REQ_CPU = 1;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_DMA  = 2'd1,
        LK_CPU  = 2'd2
    } lock_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value, input logic en);
        return (en && (value != '1)) ? value + STAT_W'(1) : value;
    endfunction

endpackage

// File: rtl/dma_ram_burst_counter.sv
// Counts consecutive locked grants to one owner and flags the grant that reaches maxBurst,
// so the arbiter can refuse to extend the lock past that point.
module dma_ram_burst_counter #(
    parameter int maxBurst = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic locked_grant_i,
    input  logic continue_i,
    output logic limit_o
);

    localparam int CW = $clog2(maxBurst + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        cnt_d = '0;
        if (locked_grant_i) begin
            // A grant that does not extend the running lock starts a fresh burst.
            cnt_d = continue_i ? cnt_q + CW'(1) : CW'(1);
        end
    end

    assign limit_o = (cnt_d == CW'(maxBurst));

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_ram_arbiter.sv
// Arbitrates one shared synchronous RAM port between the DMA engine (0) and the CPU (1).
// Define DMA_RAM_ARBITER_STATS_EN to add saturating grant/conflict statistics outputs.
module dma_ram_arbiter
    import dma_pkg::*;
#(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512,
    parameter int maxBurst    = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req0,
    input  logic                           req1,
    input  logic                           lock0,
    input  logic                           lock1,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [$clog2(nrOfEntries)-1:0] addr0,
    input  logic [$clog2(nrOfEntries)-1:0] addr1,
    input  logic [bitwidth-1:0]            wdata0,
    input  logic [bitwidth-1:0]            wdata1,
    output logic                           grant0,
    output logic                           grant1,
    output logic                           rvalid0,
    output logic                           rvalid1,
    output logic [bitwidth-1:0]            rdata0,
    output logic [bitwidth-1:0]            rdata1,
    output logic                           memWriteEnable,
    output logic [$clog2(nrOfEntries)-1:0] memAddress,
    output logic [bitwidth-1:0]            memDataIn,
    input  logic [bitwidth-1:0]            memDataOut
`ifdef DMA_RAM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]              grantCount0,
    output logic [STAT_W-1:0]              grantCount1,
    output logic [STAT_W-1:0]              conflictCount
`endif
);

    lock_e lock_q, lock_d;
    logic  last_grant_q, last_grant_d;
    logic  rvalid0_q, rvalid1_q;
    logic  locked_grant, lock_continue, burst_limit;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q       <= LK_NONE;
            last_grant_q <= 1'(REQ_CPU);
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            last_grant_q <= last_grant_d;
            rvalid0_q    <= grant0 & ~we0;
            rvalid1_q    <= grant1 & ~we1;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (lock_q == LK_DMA && req0) begin
                grant0 = 1'b1;
            end else if (lock_q == LK_CPU && req1) begin
                grant1 = 1'b1;
            end else if (req0 && req1) begin
                // Tie goes to whoever was not served last.
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign locked_grant  = (grant0 & lock0) | (grant1 & lock1);
    assign lock_continue = (grant0 && lock_q == LK_DMA) || (grant1 && lock_q == LK_CPU);

    always_comb begin
        lock_d       = LK_NONE;
        last_grant_d = last_grant_q;
        if (grant0 && lock0 && !burst_limit) begin
            lock_d = LK_DMA;
        end else if (grant1 && lock1 && !burst_limit) begin
            lock_d = LK_CPU;
        end
        if (grant0) begin
            last_grant_d = 1'(REQ_DMA);
        end else if (grant1) begin
            last_grant_d = 1'(REQ_CPU);
        end
    end

    dma_ram_burst_counter #(
        .maxBurst(maxBurst)
    ) u_burst (
        .clock         (clock),
        .reset         (reset),
        .locked_grant_i(locked_grant),
        .continue_i    (lock_continue),
        .limit_o       (burst_limit)
    );

    always_comb begin
        memWriteEnable = 1'b0;
        memAddress     = '0;
        memDataIn      = '0;
        if (grant0) begin
            memWriteEnable = we0;
            memAddress     = addr0;
            memDataIn      = wdata0;
        end else if (grant1) begin
            memWriteEnable = we1;
            memAddress     = addr1;
            memDataIn      = wdata1;
        end
    end

    // Read data of an access granted just before reset is dropped, not delivered.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata0  = rvalid0 ? memDataOut : '0;
    assign rdata1  = rvalid1 ? memDataOut : '0;

`ifdef DMA_RAM_ARBITER_STATS_EN
    logic [STAT_W-1:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt0_q   <= sat_inc(grant_cnt0_q, grant0);
            grant_cnt1_q   <= sat_inc(grant_cnt1_q, grant1);
            conflict_cnt_q <= sat_inc(conflict_cnt_q, req0 & req1);
        end
    end

    assign grantCount0   = grant_cnt0_q;
    assign grantCount1   = grant_cnt1_q;
    assign conflictCount = conflict_cnt_q;
`endif

endmodule
